alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 71 +++++++
 tb/tb_alu_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: command, external-ALU and response signals of alu_seq
interface alu_seq_if #(parameter int W = 4);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [2:0]   cmd_op;
  logic         cmd_sweep;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_res;
  logic         alu_car;
  logic         alu_of;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_res;
  logic         rsp_car;
  logic         rsp_of;
  logic [2:0]   rsp_op;
  logic         rsp_last;
  logic [7:0]   of_cnt;
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_sweep, alu_res, alu_car, alu_of, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_res, rsp_car, rsp_of, rsp_op, rsp_last, of_cnt
  );
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_sweep, alu_res, alu_car, alu_of, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_res, rsp_car, rsp_of, rsp_op, rsp_last, of_cnt
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequences single ops or 0..7 sweeps through an external combinational ALU
module alu_seq #(parameter int W = 4) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
  logic [1:0]   state_q, state_d;
  logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_res_q, rsp_res_d;
  logic [2:0]   alu_ctrl_q, alu_ctrl_d, rsp_op_q, rsp_op_d;
  logic         sweep_q, sweep_d, rsp_car_q, rsp_car_d, rsp_of_q, rsp_of_d, rsp_last_q, rsp_last_d;
  logic [7:0]   of_cnt_q, of_cnt_d;
  logic         acc, cap, hs, more;
  // next state: accept in IDLE, capture in ISSUE, release or advance the sweep on the response handshake
  always_comb begin
    acc        = bus.cmd_valid && state_q == IDLE;
    cap        = state_q == ISSUE;
    hs         = bus.rsp_ready && state_q == RESP;
    more       = sweep_q && rsp_op_q != 3'd7;
    state_d    = acc ? ISSUE : cap ? RESP : hs ? (more ? ISSUE : IDLE) : state_q;
    alu_a_d    = acc ? bus.cmd_a : alu_a_q;
    alu_b_d    = acc ? bus.cmd_b : alu_b_q;
    alu_ctrl_d = acc ? (bus.cmd_sweep ? 3'd0 : bus.cmd_op) : (hs && more) ? alu_ctrl_q + 3'd1 : alu_ctrl_q;
    sweep_d    = acc ? bus.cmd_sweep : sweep_q;
    rsp_res_d  = cap ? bus.alu_res : rsp_res_q;
    rsp_car_d  = cap ? bus.alu_car : rsp_car_q;
    rsp_of_d   = cap ? bus.alu_of : rsp_of_q;
    rsp_op_d   = cap ? alu_ctrl_q : rsp_op_q;
    rsp_last_d = cap ? (!sweep_q || alu_ctrl_q == 3'd7) : rsp_last_q;
    of_cnt_d   = (hs && rsp_of_q && of_cnt_q != 8'hff) ? of_cnt_q + 8'd1 : of_cnt_q;
  end
  // state registers; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      sweep_q    <= 1'b0;
      rsp_res_q  <= '0;
      rsp_car_q  <= 1'b0;
      rsp_of_q   <= 1'b0;
      rsp_op_q   <= '0;
      rsp_last_q <= 1'b0;
      of_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      sweep_q    <= sweep_d;
      rsp_res_q  <= rsp_res_d;
      rsp_car_q  <= rsp_car_d;
      rsp_of_q   <= rsp_of_d;
      rsp_op_q   <= rsp_op_d;
      rsp_last_q <= rsp_last_d;
      of_cnt_q   <= of_cnt_d;
    end
  end
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_car   = rsp_car_q;
  assign bus.rsp_of    = rsp_of_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.of_cnt    = of_cnt_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq against a simple external ALU model
module tb_alu_seq;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  alu_seq_if #(.W(W)) bus();
  alu_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [W:0] t5;
  // external ALU: 0 add, 1 sub (car=borrow), 2 not, 3 and, 4 or, 5 xor, 6 a>b, 7 a<=b
  always_comb begin
    t5          = '0;
    bus.alu_res = '0;
    bus.alu_car = 1'b0;
    bus.alu_of  = 1'b0;
    case (bus.alu_ctrl)
      3'd0: begin
        t5 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_res = t5[W-1:0];
        bus.alu_car = t5[W];
        bus.alu_of  = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (t5[W-1] != bus.alu_a[W-1]);
      end
      3'd1: begin
        t5 = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        bus.alu_res = t5[W-1:0];
        bus.alu_car = t5[W];
        bus.alu_of  = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (t5[W-1] != bus.alu_a[W-1]);
      end
      3'd2: bus.alu_res = ~bus.alu_a;
      3'd3: bus.alu_res = bus.alu_a & bus.alu_b;
      3'd4: bus.alu_res = bus.alu_a | bus.alu_b;
      3'd5: bus.alu_res = bus.alu_a ^ bus.alu_b;
      3'd6: bus.alu_res = {{(W-1){1'b0}}, bus.alu_a > bus.alu_b};
      default: bus.alu_res = {{(W-1){1'b0}}, bus.alu_a <= bus.alu_b};
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_chk++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.of_cnt !== 8'd0 || bus.alu_a !== 4'd0 || bus.rsp_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ready=%b valid=%b of_cnt=%0d alu_a=%h last=%b, want 1 0 0 0 0", bus.cmd_ready, bus.rsp_valid, bus.of_cnt, bus.alu_a, bus.rsp_last);
    end
  endtask

  task automatic test_single_add();
    bus.rsp_ready = 1'b1;
    bus.cmd_a = 4'b0111;
    bus.cmd_b = 4'b0001;
    bus.cmd_op = 3'd0;
    bus.cmd_sweep = 1'b0;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.alu_a !== 4'b0111 || bus.alu_b !== 4'b0001 || bus.alu_ctrl !== 3'd0) begin
      n_fail++;
      $display("FAIL add_issue: valid=%b ready=%b a=%b b=%b ctrl=%0d, want 0 0 0111 0001 0", bus.rsp_valid, bus.cmd_ready, bus.alu_a, bus.alu_b, bus.alu_ctrl);
    end
    step();
    n_chk++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 4'b1000 || bus.rsp_car !== 1'b0 || bus.rsp_of !== 1'b1 || bus.rsp_last !== 1'b1 || bus.rsp_op !== 3'd0) begin
      n_fail++;
      $display("FAIL add_rsp: valid=%b res=%b car=%b of=%b last=%b op=%0d, want 1 1000 0 1 1 0", bus.rsp_valid, bus.rsp_res, bus.rsp_car, bus.rsp_of, bus.rsp_last, bus.rsp_op);
    end
    step();
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.of_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL add_done: valid=%b ready=%b of_cnt=%0d, want 0 1 1", bus.rsp_valid, bus.cmd_ready, bus.of_cnt);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_res [8] = '{4'b1000, 4'b1110, 4'b1100, 4'b0001, 4'b0111, 4'b0110, 4'b0000, 4'b0001};
    int t;
    bus.rsp_ready = 1'b1;
    bus.cmd_a = 4'b0011;
    bus.cmd_b = 4'b0101;
    bus.cmd_op = 3'd5;
    bus.cmd_sweep = 1'b1;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_sweep = 1'b0;
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (t < 4 && bus.rsp_valid !== 1'b1) begin
        step();
        t++;
      end
      n_chk++;
      if (t !== 1 || bus.rsp_op !== k[2:0] || bus.rsp_res !== exp_res[k] || bus.rsp_last !== (k == 7)) begin
        n_fail++;
        $display("FAIL sweep[%0d]: wait=%0d op=%0d res=%b last=%b, want 1 %0d %b %b", k, t, bus.rsp_op, bus.rsp_res, bus.rsp_last, k, exp_res[k], k == 7);
      end
      step();
    end
    n_chk++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.of_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL sweep_end: ready=%b valid=%b of_cnt=%0d, want 1 0 2", bus.cmd_ready, bus.rsp_valid, bus.of_cnt);
    end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    bus.cmd_a = 4'd6;
    bus.cmd_b = 4'd3;
    bus.cmd_op = 3'd1;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_a = 4'd9;
    bus.cmd_b = 4'd9;
    bus.cmd_op = 3'd3;
    step();
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 4'd3 || bus.rsp_op !== 3'd1 || bus.rsp_car !== 1'b0 || bus.rsp_of !== 1'b0 ||
          bus.cmd_ready !== 1'b0 || bus.alu_a !== 4'd6 || bus.alu_b !== 4'd3 || bus.alu_ctrl !== 3'd1) begin
        n_fail++;
        $display("FAIL hold[%0d]: valid=%b res=%h op=%0d ready=%b a=%h b=%h ctrl=%0d, want 1 3 1 0 6 3 1", k, bus.rsp_valid, bus.rsp_res, bus.rsp_op, bus.cmd_ready, bus.alu_a, bus.alu_b, bus.alu_ctrl);
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release: valid=%b ready=%b, want 0 1", bus.rsp_valid, bus.cmd_ready);
    end
    step();
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || bus.of_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL after_release: valid=%b of_cnt=%0d, want 0 2", bus.rsp_valid, bus.of_cnt);
    end
  endtask

  task automatic test_busy();
    int n_acc = 0;
    int n_rsp = 0;
    int bad = 0;
    bus.rsp_ready = 1'b1;
    bus.cmd_b = 4'd5;
    bus.cmd_op = 3'd4;
    bus.cmd_sweep = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.cmd_ready === 1'b1) n_acc++;
      if (bus.rsp_valid === 1'b1) begin
        n_rsp++;
        if (bus.rsp_res !== 4'd7) bad++;
      end
      bus.cmd_a = bus.cmd_ready === 1'b1 ? 4'd3 : 4'hf;
      step();
    end
    bus.cmd_valid = 1'b0;
    step();
    n_chk++;
    if (n_acc !== 4 || n_rsp !== 4 || bad !== 0 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy: accepts=%0d rsps=%0d bad=%0d ready=%b, want 4 4 0 1", n_acc, n_rsp, bad, bus.cmd_ready);
    end
  endtask

  task automatic test_mid_sweep_reset();
    int seen = 0;
    bus.rsp_ready = 1'b1;
    bus.cmd_a = 4'b0011;
    bus.cmd_b = 4'b0101;
    bus.cmd_sweep = 1'b1;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_sweep = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 4 && bus.rsp_valid !== 1'b1; t++) step();
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.alu_a !== 4'd0 || bus.alu_b !== 4'd0 || bus.alu_ctrl !== 3'd0 ||
        bus.rsp_res !== 4'd0 || bus.rsp_car !== 1'b0 || bus.rsp_of !== 1'b0 || bus.rsp_op !== 3'd0 || bus.rsp_last !== 1'b0 || bus.of_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: ready=%b valid=%b a=%h b=%h ctrl=%0d res=%h car=%b of=%b op=%0d last=%b of_cnt=%0d, want 1 and all 0",
               bus.cmd_ready, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.rsp_res, bus.rsp_car, bus.rsp_of, bus.rsp_op, bus.rsp_last, bus.of_cnt);
    end
    for (int k = 0; k < 6; k++) begin
      if (bus.rsp_valid === 1'b1) seen++;
      step();
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL post_reset_rsp: responses=%0d, want 0", seen);
    end
  endtask

  task automatic test_saturation();
    bus.rsp_ready = 1'b1;
    bus.cmd_a = 4'b0111;
    bus.cmd_b = 4'b0001;
    bus.cmd_op = 3'd0;
    bus.cmd_sweep = 1'b0;
    for (int k = 0; k < 260; k++) begin
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      step();
      step();
      if (k == 253) begin
        n_chk++;
        if (bus.of_cnt !== 8'd254) begin
          n_fail++;
          $display("FAIL of_cnt_254: of_cnt=%0d, want 254", bus.of_cnt);
        end
      end
    end
    n_chk++;
    if (bus.of_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL of_cnt_sat: of_cnt=%0d, want 255", bus.of_cnt);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.cmd_sweep = 1'b0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single_add();
    test_sweep();
    test_backpressure();
    test_busy();
    test_mid_sweep_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
